// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS output scaler: gain FSM states,
// dither LFSR constants and a generic saturating clip.
package dds_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } gain_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, shifting left
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] value,
                                                    input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/dds_gain_ramp.sv
// Gain ramp controller: target/current gain registers and the IDLE/RAMP FSM.
// Current gain slews toward the target by at most RAMP_STEP per valid sample.
module dds_gain_ramp
    import dds_pkg::*;
#(
    parameter int unsigned        W_GAIN    = 16,
    parameter logic [W_GAIN-1:0]  RAMP_STEP = 16'h0400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              gain_wr,
    input  logic [W_GAIN-1:0] gain_new,
    output logic [W_GAIN-1:0] gain_cur,
    output logic              gain_busy
);

    gain_state_t       state, state_next;
    logic [W_GAIN-1:0] gain_tgt, tgt_next, cur_next;
    logic signed [W_GAIN:0] diff;
    logic [W_GAIN:0]   mag, step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gain_cur <= '0;
            gain_tgt <= '0;
        end else begin
            state    <= state_next;
            gain_cur <= cur_next;
            gain_tgt <= tgt_next;
        end
    end

    // A retarget takes effect immediately, so the step heads for the new target
    always_comb begin
        tgt_next   = gain_wr ? gain_new : gain_tgt;
        diff       = $signed({tgt_next[W_GAIN-1], tgt_next}) - $signed({gain_cur[W_GAIN-1], gain_cur});
        mag        = diff[W_GAIN] ? (W_GAIN+1)'(-diff) : (W_GAIN+1)'(diff);
        step       = (mag > {1'b0, RAMP_STEP}) ? {1'b0, RAMP_STEP} : mag;
        cur_next   = gain_cur;
        if (state == RAMP) begin
            if (RAMP_STEP == '0)
                cur_next = gain_tgt;
            else if (valid)
                cur_next = diff[W_GAIN] ? gain_cur - step[W_GAIN-1:0]
                                        : gain_cur + step[W_GAIN-1:0];
        end
        state_next = (cur_next != tgt_next) ? RAMP : IDLE;
    end

    assign gain_busy = (state == RAMP);

endmodule

// File: rtl/dds_out_scaler.sv
// DDS output scaler: gain multiply, round, offset, saturate, format for the DAC.
// Define DDS_OUT_DITHER_EN to replace the fixed rounding constant with LFSR dither.
module dds_out_scaler
    import dds_pkg::*;
#(
    parameter int unsigned        W_IN      = 8,
    parameter int unsigned        W_OUT     = 8,
    parameter int unsigned        W_GAIN    = 16,
    parameter int unsigned        GAIN_FRAC = 15,
    parameter logic [W_GAIN-1:0]  RAMP_STEP = 16'h0400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_IN-1:0]   in,
    input  logic              valid,
    input  logic              gain_wr,
    input  logic [W_GAIN-1:0] gain_new,
    input  logic [W_OUT-1:0]  offset,
    input  logic              fmt_ob,
    input  logic              sat_clr,
    output logic [W_OUT-1:0]  o,
    output logic              o_valid,
    output logic              gain_busy,
    output logic [15:0]       sat_cnt
);

    localparam int unsigned WP = W_IN + W_GAIN;
    localparam int unsigned WA = WP + 1;

    logic [W_GAIN-1:0]   gain_cur;
    logic                v1, v2;
    logic signed [WP-1:0] p1;
    logic signed [WA-1:0] s2;
    logic signed [WA-1:0] rnd, sum, s_next, off_ext;
    logic signed [63:0]  clip_val;
    logic                clipped;
    logic [W_OUT-1:0]    o_next;

    dds_gain_ramp #(
        .W_GAIN    (W_GAIN),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .gain_wr   (gain_wr),
        .gain_new  (gain_new),
        .gain_cur  (gain_cur),
        .gain_busy (gain_busy)
    );

`ifdef DDS_OUT_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (v1)
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    always_comb begin
        rnd = WA'(lfsr[GAIN_FRAC-1:0]);
    end
`else
    always_comb begin
        rnd                = '0;
        rnd[GAIN_FRAC-1]   = 1'b1;
    end
`endif

    always_comb begin
        off_ext  = WA'($signed(offset));
        sum      = WA'(p1) + rnd;
        s_next   = (sum >>> GAIN_FRAC) + off_ext;
        clip_val = sat_clip(64'(s2), W_OUT);
        clipped  = (clip_val != 64'(s2));
        o_next   = clip_val[W_OUT-1:0] ^ {fmt_ob, {(W_OUT-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            p1      <= '0;
            s2      <= '0;
            o       <= {fmt_ob, {(W_OUT-1){1'b0}}};
            o_valid <= 1'b0;
        end else begin
            v1      <= valid;
            v2      <= v1;
            o_valid <= v2;
            if (valid)
                p1 <= $signed(in) * $signed(gain_cur);
            if (v1)
                s2 <= s_next;
            if (v2)
                o  <= o_next;
        end
    end

    // Clear has priority over a coincident clip
    always_ff @(posedge clk) begin
        if (rst || sat_clr)
            sat_cnt <= '0;
        else if (v2 && clipped && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end

endmodule

// File: tb/tb_dds_out_scaler.sv
// Directed bench for dds_out_scaler: datapath vectors on an immediate-load
// instance, ramp/reset sequences on a RAMP_STEP=16'h1000 instance.
module tb_dds_out_scaler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_s = '0;
    logic        valid = 1'b0;
    logic        gain_wr = 1'b0;
    logic [15:0] gain_new = '0;
    logic [7:0]  offset = '0;
    logic        fmt_ob = 1'b1;
    logic        sat_clr = 1'b0;

    logic [7:0]  o0, o1;
    logic        ov0, ov1, busy0, busy1;
    logic [15:0] sat0, sat1;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_sat = '0;

    always #5 clk = ~clk;

    dds_out_scaler #(.RAMP_STEP(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .in(in_s), .valid(valid), .gain_wr(gain_wr),
        .gain_new(gain_new), .offset(offset), .fmt_ob(fmt_ob), .sat_clr(sat_clr),
        .o(o0), .o_valid(ov0), .gain_busy(busy0), .sat_cnt(sat0)
    );

    dds_out_scaler #(.RAMP_STEP(16'h1000)) dut1 (
        .clk(clk), .rst(rst), .in(in_s), .valid(valid), .gain_wr(gain_wr),
        .gain_new(gain_new), .offset(offset), .fmt_ob(fmt_ob), .sat_clr(sat_clr),
        .o(o1), .o_valid(ov1), .gain_busy(busy1), .sat_cnt(sat1)
    );

    typedef struct {
        logic [15:0] gain;
        logic [7:0]  din;
        logic [7:0]  off;
        logic        fmt;
        logic [7:0]  exp_o;
        logic        clip;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input logic clr);
        @(negedge clk);
        gain_wr = 1'b1; gain_new = v.gain; offset = v.off; fmt_ob = v.fmt;
        @(negedge clk) gain_wr = 1'b0;
        @(negedge clk);
        valid = 1'b1; in_s = v.din;
        @(negedge clk) valid = 1'b0;
        @(negedge clk) sat_clr = clr;
        @(negedge clk) sat_clr = 1'b0;
        if (clr) exp_sat = '0;
        else if (v.clip && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
        check("vec_o_valid", 32'(ov0), 32'd1);
        check("vec_o", 32'(o0), 32'(v.exp_o));
        check("vec_sat_cnt", 32'(sat0), 32'(exp_sat));
        @(negedge clk);
        check("hold_o_valid", 32'(ov0), 32'd0);
        check("hold_o", 32'(o0), 32'(v.exp_o));
    endtask

    initial begin
        //           gain      in      off    fmt  exp    clip
        vecs[0] = '{16'h7FFF, 8'h64, 8'h00, 1'b1, 8'hE4, 1'b0};
        vecs[1] = '{16'h7FFF, 8'h80, 8'hF6, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{16'h4000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{16'h4000, 8'h00, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{16'h4000, 8'h03, 8'h00, 1'b0, 8'h02, 1'b0};
        vecs[5] = '{16'h4000, 8'hFD, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{16'h7FFF, 8'h7F, 8'h0A, 1'b0, 8'h7F, 1'b1};
        vecs[7] = '{16'h8000, 8'h80, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[8] = '{16'h7FFF, 8'hCE, 8'h05, 1'b1, 8'h53, 1'b0};
        vecs[9] = '{16'h2000, 8'h02, 8'hFF, 1'b0, 8'h00, 1'b0};

        // reset state
        do_reset();
        check("rst_o", 32'(o0), 32'h80);
        check("rst_o_valid", 32'(ov0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_sat_cnt", 32'(sat0), 32'd0);
        check("rst_o_dut1", 32'(o1), 32'h80);

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], 1'b0);

        // clear coincident with a clip, then count restarts from zero
        run_vec(vecs[1], 1'b1);
        run_vec(vecs[1], 1'b0);

        // continuous ramp 0 -> 4000 in 16'h1000 steps
        do_reset();
        fmt_ob = 1'b0; offset = '0; in_s = 8'd64;
        @(negedge clk) begin gain_wr = 1'b1; gain_new = 16'h4000; end
        @(negedge clk) gain_wr = 1'b0;
        check("ramp_busy_start", 32'(busy1), 32'd1);
        check("ramp_gain_start", 32'(dut1.u_ramp.gain_cur), 32'h0);
        valid = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            check("ramp_gain", 32'(dut1.u_ramp.gain_cur), (j < 4) ? 32'(j * 32'h1000) : 32'h4000);
            check("ramp_busy", 32'(busy1), (j < 4) ? 32'd1 : 32'd0);
            if (j >= 3) begin
                check("ramp_o_valid", 32'(ov1), 32'd1);
                check("ramp_o", 32'(o1), 32'(8 * (j - 3)));
            end
        end
        valid = 1'b0;

        // ramp stalls during valid gaps
        do_reset();
        @(negedge clk) begin gain_wr = 1'b1; gain_new = 16'h4000; end
        @(negedge clk) begin gain_wr = 1'b0; valid = 1'b1; end
        @(negedge clk) valid = 1'b0;
        check("stall_gain1", 32'(dut1.u_ramp.gain_cur), 32'h1000);
        @(negedge clk);
        @(negedge clk) valid = 1'b1;
        check("stall_gain2", 32'(dut1.u_ramp.gain_cur), 32'h1000);
        check("stall_busy", 32'(busy1), 32'd1);
        @(negedge clk) valid = 1'b0;
        check("stall_gain3", 32'(dut1.u_ramp.gain_cur), 32'h2000);

        // retarget mid-ramp reverses in one step
        @(negedge clk) begin gain_wr = 1'b1; gain_new = 16'h1000; end
        @(negedge clk) begin gain_wr = 1'b0; valid = 1'b1; end
        check("rev_gain_hold", 32'(dut1.u_ramp.gain_cur), 32'h2000);
        check("rev_busy_hold", 32'(busy1), 32'd1);
        @(negedge clk) valid = 1'b0;
        check("rev_gain", 32'(dut1.u_ramp.gain_cur), 32'h1000);
        check("rev_busy", 32'(busy1), 32'd0);

        // reset mid-ramp with samples in flight, gain_wr coincident with rst
        fmt_ob = 1'b1; in_s = 8'd100;
        @(negedge clk) begin gain_wr = 1'b1; gain_new = 16'h4000; end
        @(negedge clk) begin gain_wr = 1'b0; valid = 1'b1; end
        @(negedge clk);
        @(negedge clk) begin
            valid = 1'b0; rst = 1'b1; gain_wr = 1'b1; gain_new = 16'h7FFF;
        end
        @(negedge clk) begin rst = 1'b0; gain_wr = 1'b0; end
        check("mrst_o_valid", 32'(ov1), 32'd0);
        check("mrst_o", 32'(o1), 32'h80);
        check("mrst_busy", 32'(busy1), 32'd0);
        check("mrst_gain", 32'(dut1.u_ramp.gain_cur), 32'h0);
        check("mrst_busy_dut0", 32'(busy0), 32'd0);
        @(negedge clk);
        check("mrst_flush", 32'(ov1), 32'd0);
        valid = 1'b1;
        @(negedge clk) valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mute_o_valid", 32'(ov1), 32'd1);
        check("mute_o", 32'(o1), 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_out_scaler.md
# dds_out_scaler

Parametrised successor of the DDS output formatter, placed between the DDS/NCO sample stream and the DAC pins. It scales each signed sample by a programmable gain, rounds, adds a DC offset, saturates to the DAC width and emits two's-complement or offset-binary codes. Gain changes are ramped over successive valid samples to avoid output steps. Clipped samples are counted for monitoring.

## Interface
- `W_IN`, 8: input sample width, signed.
- `W_OUT`, 8: output code width.
- `W_GAIN`, 16: gain width, signed.
- `GAIN_FRAC`, 15: fractional bits of the gain. Unity gain is approximately `1<<GAIN_FRAC`.
- `RAMP_STEP`, 16'h0400: maximum gain change per valid sample. A value of 0 gives an immediate load.
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in`, in, W_IN: signed sample.
- `valid`, in, 1: `in` is a valid sample this cycle.
- `gain_wr`, in, 1: one-cycle strobe that loads `gain_new` as the gain target.
- `gain_new`, in, W_GAIN: signed target gain.
- `offset`, in, W_OUT: signed DC offset in output LSBs. Quasi-static.
- `fmt_ob`, in, 1: 1 selects offset binary (MSB inverted); 0 selects two's complement. Quasi-static.
- `sat_clr`, in, 1: clears `sat_cnt`.
- `o`, out, W_OUT: DAC code.
- `o_valid`, out, 1: `o` was updated this cycle.
- `gain_busy`, out, 1: a gain ramp is in progress.
- `sat_cnt`, out, 16: saturating count of clipped samples.

## Operation
- Gain FSM has two states, IDLE and RAMP.
  - `gain_wr` writes the target register in any state. If the target differs from the current gain, the FSM goes to RAMP.
  - In RAMP, on each cycle with `valid`=1, the current gain moves toward the target by min(RAMP_STEP, |target−current|). When current equals target the FSM returns to IDLE.
  - Cycles with `valid`=0 freeze the ramp.
  - `gain_wr` during RAMP retargets the ramp; it continues from the current gain with no restart.
  - `RAMP_STEP`=0 means the current gain copies the target on the cycle after `gain_wr`.
  - `gain_busy` = (state==RAMP).
- Datapath has three stages, and every stage advances only on its valid tag.
  - S1: p = in × gain_cur, full width W_IN+W_GAIN, signed. The gain used is the current gain in the cycle `valid` is sampled.
  - S2: r = (p + R) >>> GAIN_FRAC, then s = r + sign-extended `offset`. R = 1<<(GAIN_FRAC−1), which gives round-half-up. All arithmetic uses W_IN+W_GAIN+1 bits, so there is no intermediate overflow.
  - S3: clip s to [−2^(W_OUT−1), 2^(W_OUT−1)−1].
    - `o` = clipped value with the MSB inverted if `fmt_ob`=1.
    - `o_valid` pulses for one cycle.
    - `o` holds its last value when no valid sample arrives.
- `sat_cnt` increments on each S3 sample that clipped, and stops at 16'hFFFF.
  - `sat_clr` zeroes the count.
  - `sat_clr` wins over a simultaneous clip, leaving the count at 0.

## Timing
- Latency from `valid`/`in` sampled to `o_valid`/`o` is 3 cycles. Throughput is one sample per clock.
- The gain step takes effect for the sample accepted in the cycle after the step.
- Reset values:
  - `o` = {fmt_ob, (W_OUT−1)'b0}, i.e. midscale zero in the selected format.
  - `o_valid` = 0; all stage valid tags = 0.
  - `gain_busy` = 0, state = IDLE.
  - Current gain = target gain = 0 (muted).
  - `sat_cnt` = 0.
- Reset mid-ramp aborts the ramp and re-mutes. Samples in flight are discarded and no `o_valid` pulse is produced.
- `gain_wr` coincident with `rst`: reset wins.

## Configuration
- `DDS_OUT_DITHER_EN` defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances on every valid S2 sample.
  - R is replaced by the LFSR's low GAIN_FRAC bits, zero-extended, which gives rectangular dither before truncation.
- Not defined: fixed round-half-up as described in Operation; no LFSR is present.

## Structure
- Shared package `dds_pkg`:
  - FSM state enum (IDLE, RAMP).
  - LFSR polynomial/seed constants.
  - Helper function `sat_clip(value, width)`.
- One sub-module, `dds_gain_ramp`, containing the gain FSM, the current/target registers and `gain_busy`. The datapath stays in the top block.

## Test plan
- Default parameters, gain 16'h7FFF (RAMP_STEP=0), offset 0, fmt_ob=1, in=100 → o=8'hE4 three cycles after `valid`, with an `o_valid` pulse.
- Gain 16'h7FFF, offset −10, in=−128 → o=8'h00 (offset binary). `sat_cnt` goes 0→1. Assert `sat_clr` together with the next clip → `sat_cnt`=0.
- RAMP_STEP=16'h1000, gain 0 → `gain_wr` 16'h4000, continuous `valid` → current gain steps 16'h1000, 16'h2000, 16'h3000, 16'h4000. `gain_busy` is high for 4 valid cycles, then low. With valid gaps the ramp stalls.
- Ramp in progress at 16'h2000, `gain_wr` 16'h1000 → ramp reverses to 16'h1000 in one step, then IDLE.
- `rst` asserted mid-ramp with 2 samples in flight → next cycle: `o_valid`=0, `o`=8'h80 (fmt_ob=1), `gain_busy`=0, gain 0. An input of 100 after reset then gives o=8'h80.
- In=0, any gain, offset 0: fmt_ob=0 → o=8'h00; fmt_ob=1 → o=8'h80. With DITHER_EN, long run of in=0, gain 16'h4000, offset 0 → o ∈ {8'h80}, and the LFSR sequence does not repeat within 65535 samples.
